// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder evaluation stages: default
// widths and the monitor FSM state encoding.
package approx_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/error_distance.sv
// Combinational error distance between the exact unsigned sum a+b and the
// approximate adder result; either side may be larger.
module error_distance
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0] exact;

  assign exact = {1'b0, a} + {1'b0, b};
  assign ed    = (exact >= approx_sum) ? (exact - approx_sum) : (approx_sum - exact);

endmodule

// File: rtl/approx_error_monitor.sv
// Measures error statistics of an approximate adder over a window of n
// accepted samples: error count, maximum and sum of error distances.
module approx_error_monitor
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [WIDTH:0]           approx_sum,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         err_count,
  output logic [WIDTH:0]           max_ed,
  output logic [WIDTH+CNT_W:0]     sum_ed
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_e           state_q;
  logic [CNT_W-1:0]     n_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 drain_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 s1_vld_q;
  logic [WIDTH:0]       s1_ed_q;
  logic                 s1_flag_q;

  logic [CNT_W-1:0]     err_q;
  logic [WIDTH:0]       max_q;
  logic [WIDTH+CNT_W:0] sum_q;

  logic [WIDTH:0]       ed_d;
  logic                 accept;
  logic                 last_accept;

  error_distance #(.WIDTH(WIDTH)) u_ed (
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .ed         (ed_d)
  );

  assign accept      = in_valid & ready_q;
  assign last_accept = accept & (cnt_q == (n_q - CNT_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_ed_q   <= '0;
      s1_flag_q <= 1'b0;
      err_q     <= '0;
      max_q     <= '0;
      sum_q     <= '0;
    end else begin
      // Stage 1: capture the distance of the accepted sample.
      s1_vld_q <= accept;
      if (accept) begin
        s1_ed_q   <= ed_d;
        s1_flag_q <= |ed_d;
      end

      // Stage 2: fold the registered distance into the window results.
      if (s1_vld_q) begin
        sum_q <= sum_q + {{CNT_W{1'b0}}, s1_ed_q};
        err_q <= err_q + {{(CNT_W-1){1'b0}}, s1_flag_q};
        if (s1_ed_q > max_q) max_q <= s1_ed_q;
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            n_q     <= n;
            drain_q <= 1'b0;
            if (n != '0) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) cnt_q <= cnt_q + CNT_ONE;
          if (last_accept) begin
            state_q <= ST_DRAIN;
            ready_q <= 1'b0;
            drain_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Two cycles: stage 2 retires the last sample in the first one.
          if (drain_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed and randomized windows checked against a plain-arithmetic model
// of the error statistics and the handshake timing.
module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [32:0] approx_sum;
  logic        busy, done;
  logic [15:0] err_count;
  logic [32:0] max_ed;
  logic [48:0] sum_ed;

  int total = 0;
  int bad   = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [32:0] qs[$];

  approx_error_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n          (n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .max_ed     (max_ed),
    .sum_ed     (sum_ed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".err"}, 64'(err_count), 64'd0);
    chk({tag, ".max"}, 64'(max_ed), 64'd0);
    chk({tag, ".sum"}, 64'(sum_ed), 64'd0);
  endtask

  task automatic start_win(input int nv);
    @(negedge clk);
    start = 1'b1;
    n     = 16'(nv);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push(input logic [31:0] av, input logic [31:0] bv, input logic [32:0] sv);
    qa.push_back(av); qb.push_back(bv); qs.push_back(sv);
  endtask

  task automatic push_rand(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] av, bv;
      logic [32:0] ex, sv;
      av = $urandom; bv = $urandom;
      ex = {1'b0, av} + {1'b0, bv};
      case ($urandom_range(0, 3))
        0: sv = ex;
        1: sv = ex ^ (33'd1 << $urandom_range(0, 32));
        2: sv = {1'($urandom_range(0, 1)), 32'($urandom)};
        default: sv = ex + 33'($urandom_range(1, 9));
      endcase
      push(av, bv, sv);
    end
  endtask

  // gap_mode: 0 none, 1 every other cycle, 2 random
  task automatic run_window(input string tag, input int nv, input int gap_mode, input bit extra_start);
    longint e_err = 0, e_max = 0, e_sum = 0;
    longint ex, ed;
    int acc = 0, cyc = 0;
    bit rdy;
    start_win(nv);
    while (acc < nv && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (extra_start && cyc == 3);
      n     = 16'($urandom_range(1, 9));
      case (gap_mode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2) == 1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      a = qa[acc]; b = qb[acc]; approx_sum = qs[acc];
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        ex = longint'(qa[acc]) + longint'(qb[acc]);
        ed = (ex > longint'(qs[acc])) ? ex - longint'(qs[acc]) : longint'(qs[acc]) - ex;
        if (ed != 0) e_err++;
        if (ed > e_max) e_max = ed;
        e_sum += ed;
        acc++;
      end
    end
    #1 in_valid = 1'b0;
    start = 1'b0;
    chk({tag, ".accepts"}, 64'(acc), 64'(nv));
    @(negedge clk);
    chk({tag, ".rdy_drop"}, 64'(in_ready), 64'd0);
    chk({tag, ".busy_drain"}, 64'(busy), 64'd1);
    chk({tag, ".done_e1"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, ".done_e2"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, ".done_e3"}, 64'(done), 64'd1);
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    chk({tag, ".err"}, 64'(err_count), 64'(e_err));
    chk({tag, ".max"}, 64'(max_ed), 64'(e_max));
    chk({tag, ".sum"}, 64'(sum_ed), 64'(e_sum));
    chk({tag, ".err_le_n"}, 64'(err_count <= 16'(nv)), 64'd1);
    for (int i = 0; i < acc; i++) begin
      void'(qa.pop_front()); void'(qb.pop_front()); void'(qs.pop_front());
    end
  endtask

  initial begin
    bit rdy;
    int acc;
    rst = 1'b1; start = 1'b0; n = '0; in_valid = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("post_reset");

    // single sample, ED=1
    push(32'd1, 32'd1, 33'd1);
    run_window("n1", 1, 0, 1'b0);
    chk("n1.lit_sum", 64'(sum_ed), 64'd1);

    // three samples incl. carry-out of the exact sum
    push(32'd0, 32'd0, 33'd5);
    push(32'd2, 32'd3, 33'd5);
    push(32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000);
    run_window("n3", 3, 0, 1'b0);
    chk("n3.lit_err", 64'(err_count), 64'd1);
    chk("n3.lit_max", 64'(max_ed), 64'd5);
    chk("n3.lit_sum", 64'(sum_ed), 64'd5);

    // n=0 goes straight to DONE with cleared results
    start_win(0);
    @(negedge clk);
    chk("n0.done", 64'(done), 64'd1);
    chk("n0.err", 64'(err_count), 64'd0);
    chk("n0.max", 64'(max_ed), 64'd0);
    chk("n0.sum", 64'(sum_ed), 64'd0);
    rdy = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      rdy |= in_ready;
    end
    in_valid = 1'b0;
    chk("n0.never_ready", 64'(rdy), 64'd0);
    chk("n0.done_hold", 64'(done), 64'd1);

    // toggling valid
    push_rand(4);
    run_window("gap4", 4, 1, 1'b0);

    // reset after two of four samples
    push_rand(4);
    start_win(4);
    acc = 0;
    for (int cyc = 0; cyc < 50 && acc < 2; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = qa[acc]; b = qb[acc]; approx_sum = qs[acc];
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    #2 rst = 1'b1;
    #1 chk_idle_zero("midrun_rst");
    in_valid = 1'b0;
    qa.delete(); qb.delete(); qs.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle_zero("after_rst_idle");
    in_valid = 1'b0;
    push(32'd100, 32'd23, 33'd120);
    run_window("rst_n1", 1, 0, 1'b0);
    chk("rst_n1.lit_sum", 64'(sum_ed), 64'd3);

    // extra start during RUN is ignored; same samples twice
    push_rand(6);
    for (int i = 0; i < 6; i++) begin
      qa.push_back(qa[i]); qb.push_back(qb[i]); qs.push_back(qs[i]);
    end
    run_window("nostart6", 6, 0, 1'b0);
    run_window("xstart6", 6, 0, 1'b1);

    // randomized windows with random gaps
    for (int k = 0; k < 5; k++) begin
      int nv;
      nv = $urandom_range(1, 12);
      push_rand(nv);
      run_window($sformatf("rand%0d", k), nv, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter: WIDTH, 32, operand width of the approximate adder under test.
REQ-002 Parameter: CNT_W, 16, width of the window-length and error-count fields.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a measurement window.
REQ-006 n  input  CNT_W  number of samples in the window, sampled on start.
REQ-007 in_valid  input  1  sample present on a, b, approx_sum.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 a, b  input  WIDTH  operands fed to the approximate adder.
REQ-010 approx_sum  input  WIDTH+1  approximate adder result for a, b.
REQ-011 busy  output  1  high in RUN or DRAIN.
REQ-012 done  output  1  high while results are valid (DONE state).
REQ-013 err_count  output  CNT_W  number of samples with nonzero error distance.
REQ-014 max_ed  output  WIDTH+1  largest error distance in the window.
REQ-015 sum_ed  output  WIDTH+1+CNT_W  sum of error distances in the window.

Function
REQ-016 Exact sum is the unsigned sum a+b, WIDTH+1 bits, no truncation.
REQ-017 Error distance ED = |exact - approx_sum|, unsigned, WIDTH+1 bits; approx_sum > exact is legal.
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE/DONE + start, n>0: clear err_count, max_ed, sum_ed and the sample counter, latch n, go to RUN.
REQ-020 IDLE/DONE + start, n=0: clear results, go directly to DONE.
REQ-021 start in RUN or DRAIN is ignored.
REQ-022 in_ready = 1 only in RUN; a sample is accepted on an edge where in_valid & in_ready.
REQ-023 in_valid gaps in RUN are legal; the counter advances only on accepted samples.
REQ-024 Pipeline stage 1: on the acceptance edge, register ED and the flag (ED != 0).
REQ-025 Pipeline stage 2: one edge later, sum_ed += ED, err_count += flag, max_ed = max(max_ed, ED).
REQ-026 On the edge that accepts the n-th sample, go RUN -> DRAIN; in_ready drops in the following cycle.
REQ-027 DRAIN lasts exactly 2 cycles, then goes to DONE; done is first high 3 edges after the last accept, and all results are final at that time.
REQ-028 DONE holds the results until start; there is no timeout.
REQ-029 Width rule: sum_ed shall not overflow for n ≤ 2^CNT_W-1; no saturation logic is required.
REQ-030 err_count ≤ latched n at all times.

Reset
REQ-031 rst asserted at any time, including mid-RUN or mid-DRAIN: state=IDLE, in_ready=0, busy=0, done=0, all results and pipeline registers 0.
REQ-032 Samples in flight at reset are discarded; the first window after reset needs a new start.

Structure
REQ-033 The state encoding and the WIDTH/CNT_W defaults shall live in a shared package/include file (approx_pkg) for reuse by the other approximate-adder stages.
REQ-034 The exact sum and |difference| shall be a separate combinational sub-module, error_distance (inputs a, b, approx_sum; output ed).
REQ-035 The top level holds only the FSM, the counters, the pipeline registers and the accumulators.

Verification
REQ-036 n=1, a=1, b=1, approx_sum=1 -> ED=1; done 3 edges after accept; err_count=1, max_ed=1, sum_ed=1.
REQ-037 n=3, samples (0,0,5), (2,3,5), (0xFFFF_FFFF,1,0x1_0000_0000) -> err_count=1, max_ed=5, sum_ed=5.
REQ-038 start with n=0 -> done next cycle, all results 0, in_ready never high.
REQ-039 n=4 with in_valid toggling every other cycle -> exactly 4 accepts; done 3 edges after the 4th; counts match a reference model.
REQ-040 rst pulsed after 2 of 4 samples -> all outputs 0, IDLE; a new start with n=1 yields the correct single-sample result.
REQ-041 start pulsed during RUN -> ignored; window results unchanged versus a run without the extra pulse.
